butterfly_pipe: RTL
===================

Name: butterfly_pipe

Overview:
- Parametrised, pipelined radix-2 DIT butterfly: out0 = x + y·W, out1 = x − y·W.
- Successor of the combinational butterfly. Adds:
  - generic data and twiddle widths;
  - 3-stage pipeline with valid/ready flow control;
  - convergent-free round-half-up;
  - optional per-stage ÷2 scaling;
  - output saturation with a sticky overflow flag.
- Sits between the FFT stage sequencer/memory and the next stage buffer.

Parameters:
- DATA_W, 16, width of x/y/out components, signed two's complement.
- TW_W, 16, width of twiddle components, signed Q1.(TW_W−1).
- SCALE_EN, 1, 1 = scale_i input honoured; 0 = scaling logic removed, scale_i ignored.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operand set valid.
- in_ready  out  1  block accepts operands this cycle.
- xr, xi  in  DATA_W each  x operand, signed.
- yr, yi  in  DATA_W each  y operand, signed.
- wr, wi  in  TW_W each  twiddle, signed Q1.(TW_W−1).
- scale_i  in  1  1 = halve both outputs (travels with the data).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out0_r, out0_i, out1_r, out1_i  out  DATA_W each  results, signed.
- ovf_o  out  1  sticky: at least one output component has saturated.
- ovf_clr  in  1  clears ovf_o.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - all stage valid bits = 0; out_valid = 0;
  - all output data = 0; ovf_o = 0.
  - Reset mid-operation discards every in-flight set; no partial output is produced.
- Flow control (global stall):
  - en = !out_valid || out_ready; in_ready = en (combinational).
  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
  - When en = 0, every stage register holds.
  - Latency is exactly 3 cycles with out_ready held at 1. Throughput is 1 set/cycle.
  - Bubbles are not compressed.
- Stage 1 (S1):
  - Register the 4 products yr·wr, yi·wi, yr·wi, yi·wr, each DATA_W+TW_W bits signed.
  - Register x, scale_i and the valid bit alongside.
- Stage 2 (S2):
  - pre = yr·wr − yi·wi and yr·wi + yi·wr, each DATA_W+TW_W+1 bits.
  - t = (pre + 2^(TW_W−2)) >>> (TW_W−1), giving round-half-up.
  - t is kept at DATA_W+1 bits. Example: y = −2^(DATA_W−1), W = −1 gives +2^(DATA_W−1), with no wrap.
- Stage 3 (S3):
  - s0 = x + t, s1 = x − t, each DATA_W+2 bits.
  - If scale (and SCALE_EN=1): s = (s + 1) >>> 1.
  - Saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - Register the saturated results into the output regs; out_valid = S3 valid.
- ovf_o:
  - Set on the cycle a saturating result is registered.
  - ovf_clr is a 1-cycle pulse.
  - If ovf_clr and a new overflow coincide, set wins (ovf_o = 1).
- Outputs hold stable while out_valid && !out_ready; no data change under stall.
- W = 1.0 is not representable; use 2^(TW_W−1)−1. Tests therefore allow ±1 LSB versus ideal.

Decomposition:
- Package bfly_pkg holds:
  - localparams PROD_W = DATA_W+TW_W and T_W = DATA_W+1;
  - function sat(value, width);
  - function rnd_shr(value, shift).
- One sub-module, cmplx_mult_pipe: S1+S2 complex multiply with rounding. Interface: en input, data out.
- butterfly_pipe instantiates it, plus the S3 add/sub/scale/saturate logic and the handshake.

Test Plan:
- Basic: x = (1000, −500), y = (2000, 300), W = (32767, 0), scale = 0, out_ready = 1.
  - out0 = (3000, −200), out1 = (−1000, −800), each ±1 LSB.
  - Valid exactly 3 cycles after the input handshake.
- Rotation: x = 0, y = (16384, 0), W = (0, 32767) → out0 = (0, 16384), out1 = (0, −16384), ±1.
- Saturation: x = (32767, 0), y = (32767, 0), W = (32767, 0), scale = 0.
  - out0_r = 32767, out1_r = 0 (±1), ovf_o = 1.
  - Repeat with scale = 1: out0_r = 32767 (no clip), out1_r = 0, ovf_o stays clear after ovf_clr.
- Backpressure: stream 20 random sets with out_ready toggled by a random 50% pattern.
  - Outputs match the reference model in order; no loss or duplication.
  - Outputs stable during stall; in_ready = 0 whenever out_valid && !out_ready.
- Reset mid-stream: assert rst with 3 sets in flight.
  - Next cycle out_valid = 0 and outputs = 0.
  - No stale result appears after rst deasserts.
  - Next accepted set emerges 3 cycles later.
- Corner: y = (−32768, 0), W = (−32768, 0), x = 0 → out0_r = 32767 (saturated, ovf_o = 1), out1_r = −32768.

Source files
------------

// File: rtl/bfly_pkg.sv
// Shared definitions for the pipelined radix-2 butterfly: default widths,
// a wide signed scratch type, and the rounding and saturation helpers.
package bfly_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_TW_W   = 16;

    // Product and rotated-term widths for the default configuration.
    localparam int PROD_W = DEF_DATA_W + DEF_TW_W;
    localparam int T_W    = DEF_DATA_W + 1;

    // Scratch width for intermediate arithmetic; comfortably wider than
    // DATA_W + TW_W + 2 for any sensible configuration.
    localparam int CALC_W = 64;
    typedef logic signed [CALC_W-1:0] calc_t;

    // Clamp a signed value to the range of a signed 'width'-bit number.
    function automatic calc_t sat(input calc_t value, input int width);
        calc_t hi;
        calc_t lo;
        hi = (calc_t'(1) <<< (width - 1)) - calc_t'(1);
        lo = -(calc_t'(1) <<< (width - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

    // Arithmetic right shift with round-half-up (add half an LSB, then floor).
    function automatic calc_t rnd_shr(input calc_t value, input int shift);
        if (shift <= 0) begin
            return value;
        end
        return (value + (calc_t'(1) <<< (shift - 1))) >>> shift;
    endfunction

endpackage

// File: rtl/cmplx_mult_pipe.sv
// Two-stage complex multiply t = y * W with round-half-up back to data scale.
// Stage 1 registers the four partial products, stage 2 combines and rounds
// them. The x operand, scale flag and valid bit travel alongside so the
// consumer sees them aligned with t. Everything advances only when en = 1.
module cmplx_mult_pipe
    import bfly_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TW_W   = DEF_TW_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     valid,
    input  logic signed [DATA_W-1:0] xr,
    input  logic signed [DATA_W-1:0] xi,
    input  logic signed [DATA_W-1:0] yr,
    input  logic signed [DATA_W-1:0] yi,
    input  logic signed [TW_W-1:0]   wr,
    input  logic signed [TW_W-1:0]   wi,
    input  logic                     scale,
    output logic                     t_valid,
    output logic signed [DATA_W-1:0] t_xr,
    output logic signed [DATA_W-1:0] t_xi,
    output logic                     t_scale,
    output logic signed [DATA_W:0]   tr,
    output logic signed [DATA_W:0]   ti
);

    localparam int PW = DATA_W + TW_W;

    logic                     s1_valid;
    logic signed [PW-1:0]     p_rr;
    logic signed [PW-1:0]     p_ii;
    logic signed [PW-1:0]     p_ri;
    logic signed [PW-1:0]     p_ir;
    logic signed [DATA_W-1:0] s1_xr;
    logic signed [DATA_W-1:0] s1_xi;
    logic                     s1_scale;

    calc_t pre_r;
    calc_t pre_i;
    calc_t rnd_r;
    calc_t rnd_i;

    // Stage 1 valid bit: cleared by reset so in-flight sets are discarded.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, whatever order the blocks run in.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= valid;
        end
    end

    // Stage 1 datapath: partial products plus the operands that ride along.
    // NOTE: datapath registers carry no reset; they are only ever consumed
    // when their valid bit is set, and leaving them unreset keeps the wide
    // multiplier registers free of reset muxing.
    always_ff @(posedge clk) begin
        if (en) begin
            p_rr     <= PW'(yr) * PW'(wr);
            p_ii     <= PW'(yi) * PW'(wi);
            p_ri     <= PW'(yr) * PW'(wi);
            p_ir     <= PW'(yi) * PW'(wr);
            s1_xr    <= xr;
            s1_xi    <= xi;
            s1_scale <= scale;
        end
    end

    // Stage 2 combine: real/imag sums at full precision, then round to data scale.
    always_comb begin
        pre_r = calc_t'(p_rr) - calc_t'(p_ii);
        pre_i = calc_t'(p_ri) + calc_t'(p_ir);
        rnd_r = rnd_shr(pre_r, TW_W - 1);
        rnd_i = rnd_shr(pre_i, TW_W - 1);
    end

    // Stage 2 valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_valid <= 1'b0;
        end else if (en) begin
            t_valid <= s1_valid;
        end
    end

    // Stage 2 datapath: one extra bit keeps (-full scale) * (-1) from wrapping.
    always_ff @(posedge clk) begin
        if (en) begin
            tr      <= rnd_r[DATA_W:0];
            ti      <= rnd_i[DATA_W:0];
            t_xr    <= s1_xr;
            t_xi    <= s1_xi;
            t_scale <= s1_scale;
        end
    end

endmodule

// File: rtl/butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly: out0 = x + y*W, out1 = x - y*W.
// Three register stages under a single global stall: a set presented in
// cycle c is on the outputs in cycle c+3 when downstream keeps accepting.
// Optional divide-by-two per set, saturation to DATA_W, sticky overflow.
module butterfly_pipe
    import bfly_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int TW_W     = DEF_TW_W,
    parameter bit SCALE_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] xr,
    input  logic signed [DATA_W-1:0] xi,
    input  logic signed [DATA_W-1:0] yr,
    input  logic signed [DATA_W-1:0] yi,
    input  logic signed [TW_W-1:0]   wr,
    input  logic signed [TW_W-1:0]   wi,
    input  logic                     scale_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out0_r,
    output logic signed [DATA_W-1:0] out0_i,
    output logic signed [DATA_W-1:0] out1_r,
    output logic signed [DATA_W-1:0] out1_i,
    output logic                     ovf_o,
    input  logic                     ovf_clr
);

    logic                     en;
    logic                     m_valid;
    logic signed [DATA_W-1:0] m_xr;
    logic signed [DATA_W-1:0] m_xi;
    logic                     m_scale;
    logic signed [DATA_W:0]   m_tr;
    logic signed [DATA_W:0]   m_ti;

    logic  do_scale;
    calc_t s0r;
    calc_t s0i;
    calc_t s1r;
    calc_t s1i;
    calc_t q0r;
    calc_t q0i;
    calc_t q1r;
    calc_t q1i;
    logic  sat_hit;

    // The whole pipe moves whenever the output register is empty or being drained.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    cmplx_mult_pipe #(
        .DATA_W (DATA_W),
        .TW_W   (TW_W)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .valid   (in_valid),
        .xr      (xr),
        .xi      (xi),
        .yr      (yr),
        .yi      (yi),
        .wr      (wr),
        .wi      (wi),
        .scale   (scale_i),
        .t_valid (m_valid),
        .t_xr    (m_xr),
        .t_xi    (m_xi),
        .t_scale (m_scale),
        .tr      (m_tr),
        .ti      (m_ti)
    );

    // Stage 3 add/sub, optional rounded halving, saturation and overflow detect.
    // NOTE: every variable gets its unconditional value before any 'if' that
    // may override it, so no path leaves a variable unassigned (no latch).
    always_comb begin
        do_scale = SCALE_EN && m_scale;
        s0r = calc_t'(m_xr) + calc_t'(m_tr);
        s0i = calc_t'(m_xi) + calc_t'(m_ti);
        s1r = calc_t'(m_xr) - calc_t'(m_tr);
        s1i = calc_t'(m_xi) - calc_t'(m_ti);
        if (do_scale) begin
            s0r = rnd_shr(s0r, 1);
            s0i = rnd_shr(s0i, 1);
            s1r = rnd_shr(s1r, 1);
            s1i = rnd_shr(s1i, 1);
        end
        q0r = sat(s0r, DATA_W);
        q0i = sat(s0i, DATA_W);
        q1r = sat(s1r, DATA_W);
        q1i = sat(s1i, DATA_W);
        sat_hit = (q0r != s0r) || (q0i != s0i) || (q1r != s1r) || (q1i != s1i);
    end

    // Output register: cleared on reset, loaded only with valid results,
    // frozen while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out0_r    <= '0;
            out0_i    <= '0;
            out1_r    <= '0;
            out1_i    <= '0;
        end else if (en) begin
            out_valid <= m_valid;
            if (m_valid) begin
                out0_r <= q0r[DATA_W-1:0];
                out0_i <= q0i[DATA_W-1:0];
                out1_r <= q1r[DATA_W-1:0];
                out1_i <= q1i[DATA_W-1:0];
            end
        end
    end

    // Sticky overflow: a newly registered saturating result beats a clear pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_o <= 1'b0;
        end else if (en && m_valid && sat_hit) begin
            ovf_o <= 1'b1;
        end else if (ovf_clr) begin
            ovf_o <= 1'b0;
        end
    end

endmodule
